clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 142 ++++++++++++++
 tb/tb_clock_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: run/expire controller for an external up/down counter.
//
// A run starts from IDLE on start (without stop). It clears the counter for one cycle and
// then enables it until ctr_count reaches the latched target. It then pulses expired for one
// cycle and either restarts (repeat) or returns to IDLE. Between runs the counter value is held.
//
// Ports:
//   clk, rstb         clock; asynchronous active-low reset
//   start, stop       run request (IDLE only); abort request (any busy state)
//   pause             level; freezes counting while in RUN
//   dir, target,      run configuration, latched on an accepted start
//   repeat_en
//   ctr_count         current counter value
//   ctr_done          counter wrap flag
//   ctr_up0_dn1       latched direction to the counter
//   ctr_clear         counter clear command
//   ctr_enable        counter enable command
//   busy              high in any state other than IDLE
//   expired           one-cycle expiry pulse
//   expire_cnt        saturating count of expiries since the last start
//   wrapped           sticky, set when the counter wraps during RUN
//   state_o           IDLE=0, CLEAR=1, RUN=2, EXPIRE=3
module clock_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic [CNT_W-1:0] target,
  input  logic             repeat_en,
  input  logic [CNT_W-1:0] ctr_count,
  input  logic             ctr_done,
  output logic             ctr_up0_dn1,
  output logic             ctr_clear,
  output logic             ctr_enable,
  output logic             busy,
  output logic             expired,
  output logic [7:0]       expire_cnt,
  output logic             wrapped,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StClear  = 2'd1,
    StRun    = 2'd2,
    StExpire = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             repeat_q, repeat_d;
  logic [7:0]       expire_cnt_q, expire_cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             hit;

  assign hit = (ctr_count == target_q);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      target_q     <= '0;
      repeat_q     <= 1'b0;
      expire_cnt_q <= 8'd0;
      wrapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      target_q     <= target_d;
      repeat_q     <= repeat_d;
      expire_cnt_q <= expire_cnt_d;
      wrapped_q    <= wrapped_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    target_d     = target_q;
    repeat_d     = repeat_q;
    expire_cnt_d = expire_cnt_q;
    wrapped_d    = wrapped_q;
    ctr_clear    = 1'b0;
    ctr_enable   = 1'b0;
    expired      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start together with stop is treated as no request
        if (start && !stop) begin
          dir_d        = dir;
          target_d     = target;
          repeat_d     = repeat_en;
          expire_cnt_d = 8'd0;
          wrapped_d    = 1'b0;
          state_d      = StClear;
        end
      end
      StClear: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          // clear has priority inside the counter; enable lets it take the clear this edge
          ctr_clear  = 1'b1;
          ctr_enable = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (ctr_done) wrapped_d = 1'b1;
        if (stop) begin
          state_d = StIdle;
        end else begin
          // Mealy enable: drop it in the same cycle the target is reached so no overshoot
          ctr_enable = !hit && !pause;
          if (hit) state_d = StExpire;
        end
      end
      StExpire: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          expired = 1'b1;
          if (expire_cnt_q != 8'hFF) expire_cnt_d = expire_cnt_q + 8'd1;
          state_d = repeat_q ? StClear : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ctr_up0_dn1 = dir_q;
  assign busy        = (state_q != StIdle);
  assign expire_cnt  = expire_cnt_q;
  assign wrapped     = wrapped_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: a behavioural up/down counter closes the loop; expected per-run
// results are queued when a run is started and compared on each expired pulse.
module tb_clock_ctrl;

  localparam int unsigned CntW = 8;

  typedef struct {
    int en;
    int cnt;
    int wr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstb = 1'b0;
  logic            start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0, repeat_en = 1'b0;
  logic [CntW-1:0] target = '0;
  logic [CntW-1:0] ctr_count;
  logic            ctr_done;
  logic            ctr_up0_dn1, ctr_clear, ctr_enable, busy, expired, wrapped;
  logic [7:0]      expire_cnt;
  logic [1:0]      state_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   en_run = 0;
  exp_t sb[$];

  clock_ctrl #(.CNT_W(CntW)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .dir        (dir),
    .target     (target),
    .repeat_en  (repeat_en),
    .ctr_count  (ctr_count),
    .ctr_done   (ctr_done),
    .ctr_up0_dn1(ctr_up0_dn1),
    .ctr_clear  (ctr_clear),
    .ctr_enable (ctr_enable),
    .busy       (busy),
    .expired    (expired),
    .expire_cnt (expire_cnt),
    .wrapped    (wrapped),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External counter: clear wins, done flags a wrap on the step that produced it
  logic [CntW-1:0] cnt_m = '0;
  logic            done_m = 1'b0;
  always @(posedge clk) begin
    if (ctr_clear) begin
      cnt_m  <= '0;
      done_m <= 1'b0;
    end else if (ctr_enable) begin
      done_m <= ctr_up0_dn1 ? (cnt_m == 8'd0) : (cnt_m == 8'hFF);
      cnt_m  <= ctr_up0_dn1 ? cnt_m - 8'd1 : cnt_m + 8'd1;
    end else begin
      done_m <= 1'b0;
    end
  end
  assign ctr_count = cnt_m;
  assign ctr_done  = done_m;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rstb) begin
      en_run = 0;
    end else begin
      if (state_o == 2'd1) en_run = 0;
      else if (state_o == 2'd2 && ctr_enable) en_run++;
      if (expired) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_expired", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sb_enables", en_run, e.en);
          check_eq("sb_count", int'(ctr_count), e.cnt);
          check_eq("sb_wrapped", int'(wrapped), e.wr);
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge (state CLEAR).
  task automatic start_run(input logic d, input logic [7:0] t, input logic r);
    dir = d;
    target = t;
    repeat_en = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("clear_state", int'(state_o), 1);
    check_eq("clear_cmd", int'(ctr_clear), 1);
    check_eq("clear_en", int'(ctr_enable), 1);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_expired(input int max, output int t);
    int k;
    k = 0;
    t = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!expired && k < max);
    check_eq("expired_timeout", int'(expired), 1);
    t = cyc;
  endtask

  task automatic push_exp(input int en, input int cnt, input int wr);
    exp_t e;
    e.en = en;
    e.cnt = cnt;
    e.wr = wr;
    sb.push_back(e);
  endtask

  initial begin
    int n, m, t, prev;
    #1;
    check_eq("rst_state", int'(state_o), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_outs", int'({ctr_clear, ctr_enable, ctr_up0_dn1, expired, wrapped}), 0);
    check_eq("rst_expcnt", int'(expire_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Up to 5; a second start and dir change mid-run must be ignored
    push_exp(5, 5, 0);
    start_run(1'b0, 8'd5, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; target = 8'd9; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0;
    check_eq("dir_held", int'(ctr_up0_dn1), 0);
    wait_idle(50, m);
    check_eq("up5_cycles", m + 2, 8);
    check_eq("up5_expcnt", int'(expire_cnt), 1);
    check_eq("up5_count_held", int'(ctr_count), 5);

    // Down to 253 through the wrap
    @(posedge clk); #1;
    push_exp(3, 253, 1);
    start_run(1'b1, 8'd253, 1'b0);
    check_eq("dn_dir", int'(ctr_up0_dn1), 1);
    wait_idle(50, n);
    check_eq("dn_cycles", n, 6);
    check_eq("dn_wrapped", int'(wrapped), 1);

    // Target 0: no enables, restarted run clears expire_cnt and wrapped
    @(posedge clk); #1;
    push_exp(0, 0, 0);
    start_run(1'b0, 8'd0, 1'b0);
    check_eq("t0_wrap_clr", int'(wrapped), 0);
    wait_idle(50, n);
    check_eq("t0_cycles", n, 3);
    check_eq("t0_expcnt", int'(expire_cnt), 1);

    // start with stop in IDLE is ignored
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check_eq("startstop_idle", int'(state_o), 0);

    // Repeat, target 2: period 5, expire_cnt saturates
    for (int i = 0; i < 300; i++) push_exp(2, 2, 0);
    start_run(1'b0, 8'd2, 1'b1);
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      wait_expired(20, t);
      if (i > 0) check_eq("rep_period", t - prev, 5);
      prev = t;
    end
    @(posedge clk); #1;
    check_eq("rep_restart", int'(state_o), 1);
    check_eq("rep_sat", int'(expire_cnt), 255);
    stop = 1'b1;
    #1;
    check_eq("stop_clear_cmd", int'(ctr_clear), 0);
    @(posedge clk); #1;
    stop = 1'b0;
    check_eq("rep_stopped", int'(state_o), 0);
    check_eq("rep_sat_held", int'(expire_cnt), 255);

    // Pause 3 cycles at count 2 adds 3 cycles
    @(posedge clk); #1;
    push_exp(5, 5, 0);
    start_run(1'b0, 8'd5, 1'b0);
    n = 0;
    while (!(state_o == 2'd2 && ctr_count == 8'd2) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    pause = 1'b1;
    #1;
    check_eq("pause_en", int'(ctr_enable), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; n++;
      check_eq("pause_hold", int'(ctr_count), 2);
    end
    pause = 1'b0;
    wait_idle(50, m);
    check_eq("pause_cycles", n + m, 11);

    // Stop at count 3: no expiry, count held
    @(posedge clk); #1;
    start_run(1'b0, 8'd10, 1'b0);
    n = 0;
    while (!(state_o == 2'd2 && ctr_count == 8'd3) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    stop = 1'b1;
    #1;
    check_eq("stop_en", int'(ctr_enable), 0);
    @(posedge clk); #1;
    stop = 1'b0;
    check_eq("stop_idle", int'(state_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stop_count_held", int'(ctr_count), 3);

    // Asynchronous reset during a repeating down run
    push_exp(1, 255, 1);
    push_exp(1, 255, 1);
    start_run(1'b1, 8'd255, 1'b1);
    wait_expired(20, t);
    wait_expired(20, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_state", int'(state_o), 2);
    check_eq("pre_rst_expcnt", int'(expire_cnt), 2);
    check_eq("pre_rst_dir", int'(ctr_up0_dn1), 1);
    check_eq("pre_rst_wrapped", int'(wrapped), 1);
    #2;
    rstb = 1'b0;
    #1;
    check_eq("arst_state", int'(state_o), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_outs", int'({ctr_clear, ctr_enable, ctr_up0_dn1, expired, wrapped}), 0);
    check_eq("arst_expcnt", int'(expire_cnt), 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", int'(state_o), 0);
    push_exp(3, 3, 0);
    start_run(1'b0, 8'd3, 1'b0);
    wait_idle(50, n);
    check_eq("post_rst_cycles", n, 6);
    check_eq("post_rst_expcnt", int'(expire_cnt), 1);

    repeat (2) @(posedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
